// File: rtl/fetch_pkg.sv
// Types shared between the fetch unit and the ID stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        addr_err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush dominates push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push-when-full is legal alongside it.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory issue,
// stale-response dropping on redirect, and a small queue feeding ID.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_addr_err,
    input  logic        id_ready
);

    localparam int QW = $clog2(QUEUE_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1) + 1;

    logic [31:0]  fetch_pc;
    logic [31:0]  resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic          stalled;

    logic [QW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    fetch_entry_t  q_push_data;
    fetch_entry_t  q_head;

    logic          misaligned;
    logic [CW-1:0] credit_used;
    logic          granted;
    logic          rsp;
    logic          rsp_keep;
    logic          mark_push;

    assign misaligned  = (fetch_pc[1:0] != 2'b00);
    // Slots already promised: queued words plus live (non-dropped) in-flight words.
    assign credit_used = CW'(q_count) + CW'(outstanding) - CW'(drop_cnt);

    assign imem_req  = !rst && !redirect_valid && !stalled && !misaligned
                     && (outstanding < OW'(MAX_OUTSTANDING))
                     && (credit_used < CW'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc;
    assign granted   = imem_req && imem_gnt;

    // Ignore responses with nothing outstanding (leftovers from before reset).
    assign rsp       = imem_rvalid && (outstanding != '0);
    assign rsp_keep  = rsp && (drop_cnt == '0);
    assign mark_push = !redirect_valid && misaligned && !stalled && !q_full
                     && (outstanding == drop_cnt);

    assign q_push = rsp_keep || mark_push;

    always_comb begin
        q_push_data = '0;
        if (rsp_keep) begin
            q_push_data.inst     = imem_rdata;
            q_push_data.pc       = resp_pc;
            q_push_data.addr_err = 1'b0;
        end else begin
            q_push_data.inst     = 32'h0;
            q_push_data.pc       = fetch_pc;
            q_push_data.addr_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            stalled     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            stalled     <= 1'b0;
            outstanding <= outstanding - OW'(rsp);
            drop_cnt    <= outstanding - OW'(rsp);
        end else begin
            if (granted)  fetch_pc <= fetch_pc + 32'd4;
            if (rsp_keep) resp_pc  <= resp_pc + 32'd4;
            if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
            if (mark_push) stalled <= 1'b1;
            outstanding <= outstanding + OW'(granted) - OW'(rsp);
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (id_valid && id_ready),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign id_valid    = !q_empty;
    assign id_inst     = q_empty ? 32'h0 : q_head.inst;
    assign id_pc       = q_empty ? 32'h0 : q_head.pc;
    assign id_addr_err = q_empty ? 1'b0  : q_head.addr_err;

endmodule
